capture_ctrl: RTL
=================

// Module: capture_ctrl
// PURPOSE
//  Sequencer for the sampler: runs one logic-analyser capture (pre-trigger fill, arm, trigger, post-trigger count, done).
//  Drives the sampler ctl_st0/ctl_st1/cfg_div/cfg_num and snoops the sampler output stream handshake (never drives it).
//  Sits between the host register file and the sampler.
// PARAMETERS
//  SCW  32  sample counter width (cfg_div)
//  SNW  32  sample number width (cfg_pre, cfg_post, counters)
// PORTS
//  clk          in   1    system clock
//  rst          in   1    synchronous reset, active-high
//  cmd_arm      in   1    1-cycle pulse: start a capture (ignored unless IDLE or DONE)
//  cmd_abort    in   1    1-cycle pulse: abandon capture (ignored in IDLE/DONE/FLUSH)
//  reg_div      in   SCW  host sample divider
//  reg_pre      in   SNW  host pre-trigger sample count
//  reg_post     in   SNW  host post-trigger sample count
//  ctl_st0      out  1    sampler start pulse (free-running mode)
//  ctl_st1      out  1    sampler stage-1 pulse (counted mode, cfg_num samples then tlast)
//  cfg_div      out  SCW  sampler divider
//  cfg_num      out  SNW  sampler sample count
//  sts_run      in   1    sampler running status
//  mon_tvalid   in   1    sampler sto_tvalid (snooped)
//  mon_tready   in   1    sampler sto_tready (snooped)
//  mon_trigger  in   1    sampler sto_trigger (snooped)
//  mon_tlast    in   1    sampler sto_tlast (snooped)
//  sts_state    out  3    current FSM state encoding
//  sts_pre_cnt  out  SNW  pre-trigger beats counted, saturating at reg_pre
//  sts_done     out  1    high in DONE
//  sts_aborted  out  1    sticky: last capture ended by abort; cleared on cmd_arm
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0. Reset mid-capture returns to IDLE in one cycle; no pulse is issued.
//  - beat = mon_tvalid & mon_tready. Only beats advance counters.
//  - IDLE/DONE --cmd_arm--> CFG: latch reg_div/reg_pre/reg_post into shadow regs; drive cfg_div/cfg_num from shadows from here on; clear sts_pre_cnt and sts_aborted.
//  - CFG (1 cycle) -> PRE: ctl_st0 = 1 during the CFG->PRE transition cycle only (1-cycle pulse).
//  - PRE: each beat increments sts_pre_cnt. When the count reaches pre (or pre==0 on entry), go to ARMED. A trigger beat in PRE is counted as a pre sample and otherwise ignored.
//  - ARMED: the first beat with mon_trigger=1 -> POST, with a 1-cycle ctl_st1 pulse and cfg_num=post.
//  - POST: wait for a beat with mon_tlast=1 -> DONE. post==0: sampler emits tlast on the trigger beat itself; the controller still enters POST and waits for tlast.
//  - DONE: sts_done=1; holds until cmd_arm. Counters are frozen.
//  - cmd_abort in CFG/PRE/ARMED/POST -> FLUSH: cfg_num forced 0, 1-cycle ctl_st1 pulse (none if already issued in POST); wait sts_run==0 -> IDLE with sts_aborted=1.
//  - Simultaneous events:
//    - cmd_abort beats any same-cycle trigger or tlast.
//    - cmd_arm and cmd_abort in the same cycle in DONE: arm wins.
//  - Latency: cmd_arm to ctl_st0 = 2 cycles (CFG, then pulse); trigger beat to ctl_st1 = 1 cycle (registered).
//  - ctl_st0 and ctl_st1 are registered, never high together, never high for 2 consecutive cycles.
//  - Pre counter is SNW bits and compares with ==. It cannot wrap because it stops at pre.
// STRUCTURE
//  - Shared package capture_pkg: typedef enum logic [2:0] {IDLE=0, CFG=1, PRE=2, ARMED=3, POST=4, DONE=5, FLUSH=6} capture_state_t.
//  - Single module, no sub-modules; FSM, shadow regs and the saturating pre counter are all local.
// TESTING  (bench: str_src -> sampler -> str_drn, plus capture_ctrl; 10 ns clock)
//  1 pre=4, post=3, div=0, trigger on source beat 6
//    -> ctl_st0 2 cycles after arm; ARMED after 4 beats; ctl_st1 1 cycle after trigger beat; DONE after tlast; sts_pre_cnt=4.
//  2 pre=0, post=2, trigger on first beat
//    -> PRE->ARMED immediately; trigger beat accepted; DONE after 2 more beats and tlast.
//  3 pre=4, trigger on beat 2
//    -> trigger ignored, state stays PRE; second trigger on beat 7 -> POST.
//  4 abort in ARMED (pre=2, no trigger)
//    -> FLUSH, ctl_st1 pulse with cfg_num=0, IDLE once sts_run=0; sts_aborted=1; re-arm clears it.
//  5 rst asserted for 1 cycle in POST
//    -> next cycle IDLE, all outputs 0, no ctl pulses.
//  6 drain backpressure (mon_tready low 50%), pre=3
//    -> only handshaken beats counted; sts_pre_cnt steps on beats, never exceeds 3.

Source files
------------

// File: rtl/capture_pkg.sv
// capture_pkg: shared state encoding for the capture sequencer
package capture_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CFG   = 3'd1,
        PRE   = 3'd2,
        ARMED = 3'd3,
        POST  = 3'd4,
        DONE  = 3'd5,
        FLUSH = 3'd6
    } capture_state_t;
endpackage

// File: rtl/capture_ctrl.sv
// capture_ctrl: sequences one logic-analyser capture around the sampler
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int SCW = 32,
    parameter int SNW = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_arm,
    input  logic           cmd_abort,
    input  logic [SCW-1:0] reg_div,
    input  logic [SNW-1:0] reg_pre,
    input  logic [SNW-1:0] reg_post,
    output logic           ctl_st0,
    output logic           ctl_st1,
    output logic [SCW-1:0] cfg_div,
    output logic [SNW-1:0] cfg_num,
    input  logic           sts_run,
    input  logic           mon_tvalid,
    input  logic           mon_tready,
    input  logic           mon_trigger,
    input  logic           mon_tlast,
    output logic [2:0]     sts_state,
    output logic [SNW-1:0] sts_pre_cnt,
    output logic           sts_done,
    output logic           sts_aborted
);
    capture_state_t state;
    logic [SNW-1:0] pre_s;
    logic beat;
    logic live;
    logic [SNW-1:0] pre_nxt;
    assign beat = mon_tvalid & mon_tready;
    assign live = state == CFG || state == PRE || state == ARMED || state == POST;
    assign pre_nxt = sts_pre_cnt + SNW'(1);
    assign sts_state = state;
    // FSM, shadow registers, saturating pre counter and registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pre_s       <= '0;
            cfg_div     <= '0;
            cfg_num     <= '0;
            ctl_st0     <= 1'b0;
            ctl_st1     <= 1'b0;
            sts_pre_cnt <= '0;
            sts_done    <= 1'b0;
            sts_aborted <= 1'b0;
        end else begin
            ctl_st0 <= 1'b0;
            ctl_st1 <= 1'b0;
            if ((state == IDLE || state == DONE) && cmd_arm) begin
                state       <= CFG;
                pre_s       <= reg_pre;
                cfg_div     <= reg_div;
                cfg_num     <= reg_post;
                sts_pre_cnt <= '0;
                sts_done    <= 1'b0;
                sts_aborted <= 1'b0;
            end else if (cmd_abort && live) begin
                state   <= FLUSH;
                cfg_num <= '0;
                ctl_st1 <= state != POST;
            end else begin
                case (state)
                    CFG: begin
                        state   <= PRE;
                        ctl_st0 <= 1'b1;
                    end
                    PRE: begin
                        if (sts_pre_cnt == pre_s) begin
                            state <= ARMED;
                        end else if (beat) begin
                            sts_pre_cnt <= pre_nxt;
                            if (pre_nxt == pre_s) state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (beat && mon_trigger) begin
                            state   <= POST;
                            ctl_st1 <= 1'b1;
                        end
                    end
                    POST: begin
                        if (beat && mon_tlast) begin
                            state    <= DONE;
                            sts_done <= 1'b1;
                        end
                    end
                    FLUSH: begin
                        if (!sts_run) begin
                            state       <= IDLE;
                            sts_aborted <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
